input_debouncer: RTL and testbench
==================================

// Module: input_debouncer
// PURPOSE
//   Conditions raw board inputs (SW/KEY) before they reach the adder datapath and LEDs.
//   Per channel: metastability synchronizer, then a stability-count debouncer.
//   Emits clean levels plus optional one-cycle rise/fall pulses.
//   Sits between the top-level pins and the fullAdder/LED logic in DE1_SoC.
// PARAMETERS
//   WIDTH            10          number of independent input channels
//   SYNC_STAGES      2           flip-flop stages in synchronizer, >=2
//   DEBOUNCE_CYCLES  500000      consecutive stable cycles required (10 ms @ 50 MHz), >=1
//   RESET_VAL        '0          clean_out value loaded on reset, WIDTH bits
// PORTS
//   clk        in   1      system clock (CLOCK_50 at top level)
//   reset      in   1      synchronous, active-high reset
//   raw_in     in   WIDTH  asynchronous raw pin levels, polarity preserved
//   clean_out  out  WIDTH  debounced level per channel
//   rise_pulse out  WIDTH  1-cycle pulse when clean_out bit goes 0->1
//   fall_pulse out  WIDTH  1-cycle pulse when clean_out bit goes 1->0
//   settled    out  1      1 when every channel is in ST_STABLE
// BEHAVIOUR
//   - Reset (sync, active-high): sync chain <= RESET_VAL, clean_out <= RESET_VAL, counters <= 0,
//     all channels ST_STABLE, rise/fall_pulse <= 0, settled <= 1. Reset wins over all other events.
//   - Sync: raw_in passes through SYNC_STAGES flops; the last stage is s_in.
//   - Per channel FSM, states ST_STABLE / ST_COUNTING:
//     ST_STABLE: s_in == clean_out -> stay, cnt = 0; s_in != clean_out -> ST_COUNTING, cnt = 1.
//     ST_COUNTING: s_in == clean_out (glitch) -> ST_STABLE, cnt = 0, no output change.
//       s_in != clean_out and cnt == DEBOUNCE_CYCLES-1 -> clean_out <= s_in, pulse, ST_STABLE, cnt = 0.
//       Otherwise cnt++.
//   - With DEBOUNCE_CYCLES == 1: clean_out follows s_in with 1-cycle delay.
//   - Latency: a level held stable reaches clean_out exactly SYNC_STAGES + DEBOUNCE_CYCLES
//     rising edges after the first edge that samples it.
//   - Glitch rejection: any excursion shorter than DEBOUNCE_CYCLES at s_in is discarded and
//     restarts the count; clean_out never toggles more than once per DEBOUNCE_CYCLES cycles.
//   - Counter width $clog2(DEBOUNCE_CYCLES+1); never wraps, because it clears at terminal count.
//   - Channels are fully independent. Simultaneous changes on several bits qualify in the same cycle.
//   - Pulses are registered, asserted in the same cycle clean_out updates, for exactly 1 cycle.
//   - settled is registered: 0 while any channel is ST_COUNTING.
//   - Reset mid-count: the count is abandoned and clean_out returns to RESET_VAL next edge.
//     After reset a held input re-qualifies in SYNC_STAGES + DEBOUNCE_CYCLES cycles.
// CONFIGURATION
//   INPUT_DEBOUNCER_EDGE_EN defined: rise_pulse/fall_pulse generated as above.
//   Not defined: rise_pulse/fall_pulse tied to '0, no edge registers built. Ports remain present;
//   clean_out/settled behaviour unchanged.
// STRUCTURE
//   debounce_pkg: typedef enum logic {ST_STABLE, ST_COUNTING} db_state_t;
//     localparam CLK_HZ = 50_000_000; localparam DB_10MS = CLK_HZ/100.
//   Sub-module debounce_channel (one bit: sync chain, FSM, counter, edge flops);
//     input_debouncer instantiates WIDTH copies via generate and ANDs stable flags into settled.
// TESTING (sim with DEBOUNCE_CYCLES=4, SYNC_STAGES=2, WIDTH=3, RESET_VAL=3'b000)
//   1. reset held 3 cycles, raw_in=3'b111 -> clean_out=000, pulses=0, settled=1 during reset.
//   2. raw_in[0] 0->1, held -> clean_out[0]=1 exactly 6 edges later; rise_pulse[0]=1 for 1 cycle;
//      settled=0 during the count.
//   3. raw_in[1] high for 3 cycles, then low -> clean_out[1] stays 0; no pulse; settled returns to 1.
//   4. raw_in[2] bounce 1,0,1,0,1 then held 1 -> clean_out[2] rises once, 6 cycles after the final 1.
//   5. raw_in 000->011 in one cycle -> clean_out[1:0] both update on the same edge; two rise pulses.
//   6. Reset asserted at count 2 of a pending change -> clean_out=000 next edge; after release,
//      held input qualifies 6 cycles later. Rerun 2 without INPUT_DEBOUNCER_EDGE_EN: pulses stay 0.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and constants for the input debouncer.
// Holds the per-channel FSM state encoding and board-clock timing constants.
// No logic of its own; imported by debounce_channel and input_debouncer.
package debounce_pkg;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } db_state_t;

  localparam int CLK_HZ  = 50_000_000;
  localparam int DB_10MS = CLK_HZ / 100;

endpackage : debounce_pkg

// File: rtl/debounce_channel.sv
// One-bit input conditioner: synchronizer chain, stability-count FSM, optional edge pulses.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES edges from first sampling edge to o_clean.
// Backpressure: none; free-running. Edge pulses only built with INPUT_DEBOUNCER_EDGE_EN.
//
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_raw          : asynchronous raw pin level
//   o_clean        : debounced level
//   o_rise/o_fall  : 1-cycle pulse on o_clean 0->1 / 1->0 (0 without INPUT_DEBOUNCER_EDGE_EN)
//   o_stable       : 1 while FSM is in ST_STABLE
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = DB_10MS,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_clean,
  output logic o_rise,
  output logic o_fall,
  output logic o_stable
);

  localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  db_state_t              r_state;
  db_state_t              w_state_nxt;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_nxt;
  logic                   r_clean;
  logic                   w_update;
  logic                   w_s_in;

  // Synchronizer: shift in at bit 0, sample the far end.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  assign w_s_in = r_sync[SYNC_STAGES-1];

  // State register (counter and clean level travel with the state).
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_STABLE;
      r_cnt   <= '0;
      r_clean <= RESET_VAL;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_update) begin
        r_clean <= w_s_in;
      end
    end
  end

  // Next-state logic. The first differing sample already counts as 1, so a
  // single-cycle qualification updates straight out of ST_STABLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_update    = 1'b0;
    case (r_state)
      ST_STABLE: begin
        if (w_s_in != r_clean) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_update = 1'b1;
          end else begin
            w_state_nxt = ST_COUNTING;
            w_cnt_nxt   = CW'(1);
          end
        end
      end
      ST_COUNTING: begin
        if (w_s_in == r_clean) begin
          w_state_nxt = ST_STABLE;          // glitch: drop the count
        end else if (r_cnt == TERM) begin
          w_update    = 1'b1;
          w_state_nxt = ST_STABLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = ST_STABLE;
    endcase
  end

  // Outputs.
  always_comb begin
    o_stable = (r_state == ST_STABLE);
    o_clean  = r_clean;
  end

`ifdef INPUT_DEBOUNCER_EDGE_EN
  logic r_rise;
  logic r_fall;

  // Registered alongside r_clean so the pulse lines up with the level change.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_update &  w_s_in;
      r_fall <= w_update & ~w_s_in;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;
`else
  assign o_rise = 1'b0;
  assign o_fall = 1'b0;
`endif

endmodule : debounce_channel

// File: rtl/input_debouncer.sv
// Conditions WIDTH raw board inputs into clean levels with optional edge pulses.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES edges per channel; channels independent.
// Backpressure: none. Optional macro INPUT_DEBOUNCER_EDGE_EN enables rise/fall pulses.
//
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_raw_in       : raw pin levels, polarity preserved
//   o_clean_out    : debounced levels
//   o_rise_pulse   : 1-cycle pulse per bit on 0->1 (0 when INPUT_DEBOUNCER_EDGE_EN undefined)
//   o_fall_pulse   : 1-cycle pulse per bit on 1->0 (0 when INPUT_DEBOUNCER_EDGE_EN undefined)
//   o_settled      : 1 when every channel is in ST_STABLE
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int               WIDTH           = 10,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_raw_in,
  output logic [WIDTH-1:0] o_clean_out,
  output logic [WIDTH-1:0] o_rise_pulse,
  output logic [WIDTH-1:0] o_fall_pulse,
  output logic             o_settled
);

  logic [WIDTH-1:0] w_stable;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (RESET_VAL[g])
    ) u_ch (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_raw   (i_raw_in[g]),
      .o_clean (o_clean_out[g]),
      .o_rise  (o_rise_pulse[g]),
      .o_fall  (o_fall_pulse[g]),
      .o_stable(w_stable[g])
    );
  end

  // Per-channel stable flags are state-register outputs, so this stays register-driven.
  assign o_settled = &w_stable;

endmodule : input_debouncer

// File: tb/tb_input_debouncer.sv
module tb_input_debouncer;

  localparam int         W   = 3;
  localparam int         SS  = 2;
  localparam int         DC  = 4;
  localparam logic [W-1:0] RV = 3'b000;

`ifdef INPUT_DEBOUNCER_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         i_reset;
  logic [W-1:0] i_raw_in;
  logic [W-1:0] o_clean_out;
  logic [W-1:0] o_rise_pulse;
  logic [W-1:0] o_fall_pulse;
  logic         o_settled;

  always #5 clk = ~clk;

  input_debouncer #(
    .WIDTH          (W),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DC),
    .RESET_VAL      (RV)
  ) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_raw_in    (i_raw_in),
    .o_clean_out (o_clean_out),
    .o_rise_pulse(o_rise_pulse),
    .o_fall_pulse(o_fall_pulse),
    .o_settled   (o_settled)
  );

  int    n_vec  = 0;
  int    n_miss = 0;
  string phase  = "init";

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s.%s got=%0h exp=%0h @%0t", phase, tag, act, exp, $time);
    end
  endtask

  // Reference model: two-stage delay line plus a run length of samples that
  // disagree with the clean level; the level flips once the run reaches DC.
  logic [W-1:0] m_s0, m_s1, m_clean;
  int           m_run [W];
  logic [9:0]   sb_q [$];

  task automatic model_step(input logic [W-1:0] raw, input logic rst, output logic [9:0] e);
    logic [W-1:0] s_in, rise, fall;
    logic         settled;
    rise    = '0;
    fall    = '0;
    settled = 1'b1;
    if (rst) begin
      m_s0    = RV;
      m_s1    = RV;
      m_clean = RV;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      s_in = m_s1;
      for (int i = 0; i < W; i++) begin
        if (s_in[i] != m_clean[i]) begin
          m_run[i]++;
          if (m_run[i] == DC) begin
            m_clean[i] = s_in[i];
            if (s_in[i]) rise[i] = 1'b1;
            else         fall[i] = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
        if (m_run[i] != 0) settled = 1'b0;
      end
      m_s1 = m_s0;
      m_s0 = raw;
    end
    if (!EDGE_EN) begin
      rise = '0;
      fall = '0;
    end
    e = {m_clean, rise, fall, settled};
  endtask

  // Drive one cycle, predict, then check the DUT after the edge.
  task automatic tick(input logic [W-1:0] raw, input logic rst);
    logic [9:0] e;
    @(negedge clk);
    i_raw_in = raw;
    i_reset  = rst;
    model_step(raw, rst, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("clean",   32'(o_clean_out),  32'(e[9:7]));
    chk("rise",    32'(o_rise_pulse), 32'(e[6:4]));
    chk("fall",    32'(o_fall_pulse), 32'(e[3:1]));
    chk("settled", 32'(o_settled),    32'(e[0]));
  endtask

  initial begin
    int lat, lat0, lat1, n_rise2, n_tog2;
    logic [W-1:0] prev, r;
    int hold;

    i_reset  = 1'b1;
    i_raw_in = 3'b111;

    // 1. reset held with all inputs high
    phase = "reset";
    for (int i = 0; i < 3; i++) tick(3'b111, 1'b1);
    chk("clean_rst", 32'(o_clean_out), 32'(3'b000));
    chk("settled_rst", 32'(o_settled), 32'd1);
    phase = "idle";
    for (int i = 0; i < 4; i++) tick(3'b000, 1'b0);

    // 2. single channel qualifies after SS+DC edges
    phase = "t2";
    lat = -1;
    for (int n = 1; n <= 10; n++) begin
      tick(3'b001, 1'b0);
      if (n == 3) chk("settled_counting", 32'(o_settled), 32'd0);
      if (lat < 0 && o_clean_out[0]) lat = n;
    end
    chk("latency", 32'(lat), 32'd6);

    // 3. 3-cycle pulse on bit 1 is rejected
    phase = "t3";
    for (int i = 0; i < 3; i++) tick(3'b011, 1'b0);
    for (int i = 0; i < 8; i++) tick(3'b001, 1'b0);
    chk("clean1_kept_low", 32'(o_clean_out[1]), 32'd0);

    // 4. bounce on bit 2 then hold
    phase = "t4";
    n_rise2 = 0;
    n_tog2  = 0;
    prev    = o_clean_out;
    lat     = -1;
    for (int i = 0; i < 5; i++) begin
      tick((i % 2 == 0) ? 3'b101 : 3'b001, 1'b0);
      if (o_rise_pulse[2]) n_rise2++;
      if (o_clean_out[2] != prev[2]) n_tog2++;
      prev = o_clean_out;
    end
    for (int n = 1; n <= 10; n++) begin
      tick(3'b101, 1'b0);
      if (o_rise_pulse[2]) n_rise2++;
      if (o_clean_out[2] != prev[2]) n_tog2++;
      if (lat < 0 && o_clean_out[2]) lat = n;
      prev = o_clean_out;
    end
    chk("toggles", 32'(n_tog2), 32'd1);
    chk("rise_count", 32'(n_rise2), EDGE_EN ? 32'd1 : 32'd0);
    // final '1' of the bounce sits one cycle before the hold loop
    chk("latency", 32'(lat + 1), 32'd6);

    // 5. simultaneous change on two bits
    phase = "t5";
    for (int i = 0; i < 10; i++) tick(3'b000, 1'b0);
    lat0 = -1;
    lat1 = -1;
    for (int n = 1; n <= 10; n++) begin
      tick(3'b011, 1'b0);
      if (lat0 < 0 && o_clean_out[0]) lat0 = n;
      if (lat1 < 0 && o_clean_out[1]) lat1 = n;
    end
    chk("same_edge0", 32'(lat0), 32'd6);
    chk("same_edge1", 32'(lat1), 32'd6);

    // 6. reset mid-count, then requalify
    phase = "t6";
    for (int i = 0; i < 4; i++) tick(3'b111, 1'b0);
    tick(3'b111, 1'b1);
    chk("clean_after_rst", 32'(o_clean_out), 32'(3'b000));
    lat = -1;
    for (int n = 1; n <= 10; n++) begin
      tick(3'b111, 1'b0);
      if (lat < 0 && o_clean_out == 3'b111) lat = n;
    end
    chk("requalify", 32'(lat), 32'd6);

    // random held levels with occasional short glitches
    phase = "rand";
    for (int k = 0; k < 30; k++) begin
      r    = 3'($urandom_range(0, 7));
      hold = $urandom_range(1, 7);
      for (int j = 0; j < hold; j++) tick(r, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_input_debouncer
